pipe_stage_elastic: RTL and testbench

Parametrised elastic pipeline register: a chain of DEPTH data stages, each with its own valid bit, a valid/ready handshake on both sides, and a synchronous flush. It succeeds the plain enable/clear pipeline flop for inter-stage registers in the RISC-V core. Stalls come from downstream backpressure rather than a global enable, and empty stages collapse so that bubbles are squeezed out. It sits between core pipeline stages such as IF/ID and ID/EX, and between fetch and the instruction queue.

---
 rtl/pipe_stage_elastic.sv | 81 ++++++++
 tb/tb_pipe_stage_elastic.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: DEPTH valid/data stages with valid/ready handshake,
// bubble collapse toward the output and a synchronous flush of all held entries.
module pipe_stage_elastic #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] occupancy
);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [CNT_W-1:0] r_occ;

    logic [DEPTH-1:0] w_rdy;
    logic [DEPTH-1:0] w_valid_nxt;

    function automatic logic [CNT_W-1:0] f_popcount(input logic [DEPTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    // A stage may load unless it and every stage after it is full and the
    // output is stalled; evaluated as a suffix-AND to keep the chain acyclic.
    always_comb begin
        logic w_tail_full;
        w_rdy       = '0;
        w_tail_full = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_tail_full = w_tail_full & r_valid[i];
            w_rdy[i]    = !w_tail_full || out_ready;
        end
    end

    always_comb begin
        w_valid_nxt = r_valid;
        if (flush) begin
            w_valid_nxt = '0;
        end else begin
            if (w_rdy[0]) w_valid_nxt[0] = in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                if (w_rdy[i]) w_valid_nxt[i] = r_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_occ   <= '0;
            for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_occ   <= f_popcount(w_valid_nxt);
            // Flush only drops valid bits; payload registers keep their contents.
            if (!flush) begin
                if (w_rdy[0]) r_data[0] <= in_data;
                for (int i = 1; i < DEPTH; i++) begin
                    if (w_rdy[i]) r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign in_ready  = w_rdy[0] && !flush;
    assign out_valid = r_valid[DEPTH-1] && !flush;
    assign out_data  = r_data[DEPTH-1];
    assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: DEPTH=2 and DEPTH=1 instances share one stimulus;
// a FIFO-with-positions model predicts every output each cycle.
module tb_pipe_stage_elastic;

    localparam int DA = 2;
    localparam int DB = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [1:0]  a_occ;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [0:0]  b_occ;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.WIDTH(32), .DEPTH(DA)) u_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    pipe_stage_elastic #(.WIDTH(32), .DEPTH(DB)) u_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: entries in acceptance order, each with its stage position.
    logic [31:0] md [2][4];
    int          mp [2][4];
    int          msz [2];
    int          m_d, m_lim;
    bit          m_ir, m_ov;

    initial begin
        msz[0] = 0;
        msz[1] = 0;
    end

    function automatic int dep(input int k);
        return (k == 0) ? DA : DB;
    endfunction

    function automatic bit exp_ir(input int k);
        return !flush && ((msz[k] < dep(k)) || out_ready);
    endfunction

    function automatic bit exp_ov(input int k);
        return !flush && (msz[k] > 0) && (mp[k][0] == dep(k) - 1);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_d = dep(k);
            if (reset || flush) begin
                msz[k] = 0;
            end else begin
                m_ir = (msz[k] < m_d) || out_ready;
                m_ov = (msz[k] > 0) && (mp[k][0] == m_d - 1);
                if (m_ov && out_ready) begin
                    for (int j = 0; j < msz[k] - 1; j++) begin
                        md[k][j] = md[k][j+1];
                        mp[k][j] = mp[k][j+1];
                    end
                    msz[k] = msz[k] - 1;
                end
                m_lim = m_d - 1;
                for (int j = 0; j < msz[k]; j++) begin
                    mp[k][j] = (mp[k][j] + 1 < m_lim) ? mp[k][j] + 1 : m_lim;
                    m_lim    = mp[k][j] - 1;
                end
                if (in_valid && m_ir) begin
                    md[k][msz[k]] = in_data;
                    mp[k][msz[k]] = 0;
                    msz[k]        = msz[k] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a.in_ready",  32'(a_in_ready),  32'(exp_ir(0)));
            chk("a.out_valid", 32'(a_out_valid), 32'(exp_ov(0)));
            chk("a.occupancy", 32'(a_occ),       32'(msz[0]));
            if (exp_ov(0)) chk("a.out_data", a_out_data, md[0][0]);
            chk("b.in_ready",  32'(b_in_ready),  32'(exp_ir(1)));
            chk("b.out_valid", 32'(b_out_valid), 32'(exp_ov(1)));
            chk("b.occupancy", 32'(b_occ),       32'(msz[1]));
            if (exp_ov(1)) chk("b.out_data", b_out_data, md[1][0]);
        end
    end

    task automatic cyc(input bit rst, input bit fl, input bit iv, input logic [31:0] d,
                       input bit ordy);
        @(posedge clk);
        #1;
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
    endtask

    initial begin
        // Reset, then idle
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("rst.a.out_valid", 32'(a_out_valid), 0);
        chk("rst.a.out_data",  a_out_data, 0);
        chk("rst.a.occupancy", 32'(a_occ), 0);
        chk("rst.a.in_ready",  32'(a_in_ready), 1);
        chk("rst.b.out_data",  b_out_data, 0);
        chk_en = 1'b1;

        // Stream with no backpressure
        cyc(0, 0, 1, 32'h11, 1);
        cyc(0, 0, 1, 32'h22, 1);
        cyc(0, 0, 1, 32'h33, 1);
        chk("stream.first", a_out_data, 32'h11);
        chk("stream.occ",   32'(a_occ), 2);
        cyc(0, 0, 0, 0, 1);
        chk("stream.second", a_out_data, 32'h22);
        cyc(0, 0, 0, 0, 1);
        chk("stream.third", a_out_data, 32'h33);
        cyc(0, 0, 0, 0, 1);
        chk("stream.empty", 32'(a_out_valid), 0);

        // Backpressure fill then release
        cyc(0, 0, 1, 32'hA0, 0);
        cyc(0, 0, 1, 32'hA1, 0);
        cyc(0, 0, 1, 32'hA2, 0);
        chk("bp.in_ready", 32'(a_in_ready), 0);
        chk("bp.occ",      32'(a_occ), 2);
        chk("bp.hold",     a_out_data, 32'hA0);
        cyc(0, 0, 1, 32'hA2, 1);
        chk("bp.out0", a_out_data, 32'hA0);
        cyc(0, 0, 0, 0, 1);
        chk("bp.out1", a_out_data, 32'hA1);
        cyc(0, 0, 0, 0, 1);
        chk("bp.out2", a_out_data, 32'hA2);
        cyc(0, 0, 0, 0, 1);

        // Bubble collapse
        cyc(0, 0, 1, 32'h5, 0);
        cyc(0, 0, 0, 0, 0);
        chk("bub.not_yet", 32'(a_out_valid), 0);
        cyc(0, 0, 0, 0, 0);
        chk("bub.arrived", a_out_data, 32'h5);
        chk("bub.in_ready", 32'(a_in_ready), 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h6, 0);
        chk("bub.accept6", 32'(a_in_ready), 1);
        cyc(0, 0, 0, 0, 0);
        chk("bub.occ2", 32'(a_occ), 2);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("bub.out6", a_out_data, 32'h6);
        cyc(0, 0, 0, 0, 1);

        // Full with simultaneous in and out
        cyc(0, 0, 1, 32'h1, 0);
        cyc(0, 0, 1, 32'h2, 0);
        cyc(0, 0, 1, 32'h3, 1);
        chk("full.in_ready", 32'(a_in_ready), 1);
        chk("full.out1",     a_out_data, 32'h1);
        cyc(0, 0, 0, 0, 0);
        chk("full.occ", 32'(a_occ), 2);
        chk("full.out2", a_out_data, 32'h2);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("full.out3", a_out_data, 32'h3);
        cyc(0, 0, 0, 0, 1);

        // Flush with a simultaneous offer
        cyc(0, 0, 1, 32'hB0, 0);
        cyc(0, 0, 1, 32'hB1, 0);
        cyc(0, 1, 1, 32'hB2, 1);
        chk("flush.in_ready",  32'(a_in_ready), 0);
        chk("flush.out_valid", 32'(a_out_valid), 0);
        cyc(0, 0, 0, 0, 1);
        chk("flush.occ", 32'(a_occ), 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Mid-stream reset with DEPTH=1
        cyc(0, 0, 1, 32'h7, 0);
        cyc(0, 0, 0, 0, 0);
        chk("d1.out7", b_out_data, 32'h7);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("d1rst.out_valid", 32'(b_out_valid), 0);
        chk("d1rst.out_data",  b_out_data, 0);
        chk("d1rst.occ",       32'(b_occ), 0);
        chk("d1rst.in_ready",  32'(b_in_ready), 1);

        // Mixed traffic pattern
        for (int i = 0; i < 40; i++) begin
            cyc(0, (i == 20), (i % 3 != 2), 32'hC000 + 32'(i), (i % 5 < 3));
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
